// File: rtl/bcd_display_scheduler_pkg.sv
// bcd_display_scheduler_pkg: shared state, digit-select encodings and BCD limit
package bcd_display_scheduler_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, SHOW, DONE} state_t;

   typedef enum logic [1:0] {SEL_ONES, SEL_TENS, SEL_HUNDREDS, SEL_THOUSANDS} dsel_t;

   localparam int BCD_MAX = 9999;

endpackage

// File: rtl/bcd_digit_scanner.sv
// bcd_digit_scanner: multiplexes four latched BCD digits onto active-low anodes with leading-zero blanking
module bcd_digit_scanner
   import bcd_display_scheduler_pkg::*;
#(
   parameter int SCAN_CYCLES = 50000,
   localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] digits,
   output logic [3:0]  digit_en,
   output logic [3:0]  digit_val
);

   logic [SW-1:0] cnt;
   dsel_t         sel;
   logic [3:0]    blank;
   logic          wrap;

   assign wrap = cnt == SW'(SCAN_CYCLES - 1);

   // a digit is blanked when it and every higher digit are zero; ones always shows
   always_comb begin
      blank[3] = digits[15:12] == 4'd0;
      blank[2] = blank[3] && digits[11:8] == 4'd0;
      blank[1] = blank[2] && digits[7:4] == 4'd0;
      blank[0] = 1'b0;
   end

   // free-running scan: advance the digit select on each counter wrap and register the anode drive
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         sel       <= SEL_ONES;
         digit_en  <= 4'b1111;
         digit_val <= 4'd0;
      end else begin
         cnt       <= wrap ? '0 : cnt + 1'b1;
         sel       <= wrap ? dsel_t'(sel + 2'd1) : sel;
         digit_en  <= blank[sel] ? 4'b1111 : ~(4'b0001 << sel);
         digit_val <= digits[{sel, 2'b00} +: 4];
      end
   end

endmodule

// File: rtl/bcd_display_scheduler.sv
// bcd_display_scheduler: walks a snapshot of array results through a shared BCD converter onto a 4-digit display
module bcd_display_scheduler
   import bcd_display_scheduler_pkg::*;
#(
   parameter int BITWIDTH     = 16,
   parameter int NUM_WORDS    = 16,
   parameter int DWELL_CYCLES = 50000000,
   parameter int SCAN_CYCLES  = 50000,
   localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
   localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic                          hold,
   input  logic [NUM_WORDS*BITWIDTH-1:0] results,
   input  logic [3:0]                    bcd_thousands,
   input  logic [3:0]                    bcd_hundreds,
   input  logic [3:0]                    bcd_tens,
   input  logic [3:0]                    bcd_ones,
   output logic [BITWIDTH-1:0]           bin_out,
   output logic [IW-1:0]                 word_idx,
   output logic [3:0]                    digit_en,
   output logic [3:0]                    digit_val,
   output logic                          ovf,
   output logic                          busy,
   output logic                          done
);

   state_t               state, state_nxt;
   logic [BITWIDTH-1:0]  snap [NUM_WORDS];
   logic [DW-1:0]        cnt;
   logic [15:0]          digits;
   logic                 last, dwell_end;

   assign last      = word_idx == IW'(NUM_WORDS - 1);
   assign dwell_end = cnt == DW'(DWELL_CYCLES - 1) && !hold;
   assign busy      = state == LOAD || state == SHOW;
   assign done      = state == DONE;

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // next state: LOAD is a single converter-settle cycle, SHOW dwells, DONE is a one-cycle marker
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    state_nxt = start ? LOAD : IDLE;
         LOAD:    state_nxt = SHOW;
         SHOW:    state_nxt = dwell_end ? (last ? DONE : LOAD) : SHOW;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // snapshot, word sequencing, digit latching and dwell counting
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_WORDS; k++) snap[k] <= '0;
         bin_out  <= '0;
         word_idx <= '0;
         digits   <= '0;
         ovf      <= 1'b0;
         cnt      <= '0;
      end else begin
         unique case (state)
            IDLE: if (start) begin
               for (int k = 0; k < NUM_WORDS; k++) snap[k] <= results[k*BITWIDTH +: BITWIDTH];
               word_idx <= '0;
               bin_out  <= results[0 +: BITWIDTH];
            end
            LOAD: begin
               digits <= {bcd_thousands, bcd_hundreds, bcd_tens, bcd_ones};
               ovf    <= 32'(bin_out) > BCD_MAX;
               cnt    <= '0;
            end
            SHOW: begin
               if (!hold) cnt <= cnt + 1'b1;
               if (dwell_end && !last) begin
                  word_idx <= word_idx + 1'b1;
                  bin_out  <= snap[word_idx + 1'b1];
               end
            end
            default: ;
         endcase
      end
   end

   bcd_digit_scanner #(.SCAN_CYCLES(SCAN_CYCLES)) u_scan (
      .clk       (clk),
      .rst_n     (rst_n),
      .digits    (digits),
      .digit_en  (digit_en),
      .digit_val (digit_val)
   );

endmodule
